// File: rtl/ex_muldiv_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_if
//   Bundles the ID/EX-side request signals and the HI/LO/status outputs of the
//   iterative multiply/divide unit.
//
//   master : the pipeline side (drives requests, observes HI/LO and status)
//   slave  : the multiply/divide unit
//
//   start  request launch (only accepted when the unit is idle)
//   op     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a  rs value (multiplicand / dividend)
//   src_b  rt value (multiplier / divisor)
//   cancel pipeline flush; aborts an in-flight operation
//   hi_we  MTHI write enable
//   lo_we  MTLO write enable
//   wdata  MTHI/MTLO data
//   hi     HI register
//   lo     LO register
//   busy   operation in flight
//   done   one-cycle pulse when a new result lands in HI/LO
// ----------------------------------------------------------------------------
interface ex_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              cancel;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              done;

    modport master (
        output start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv
//   Iterative radix-2 multiply/divide unit in the EX stage. Executes
//   MULT/MULTU/DIV/DIVU over DATA_W iterations on operand magnitudes, applies
//   the sign fix-up in a final cycle and owns the architectural HI/LO
//   registers, which MTHI/MTLO may also write while the unit is idle.
//
//   clk  clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  ex_muldiv_if.slave: start/op/src_a/src_b/cancel/hi_we/lo_we/wdata in,
//        hi/lo/busy/done out
//
//   Timing: a start accepted at edge E0 makes busy high from E0; iterations
//   run on E1..E(DATA_W); the result and a one-cycle done appear at
//   E(DATA_W+1).
// ----------------------------------------------------------------------------
module ex_muldiv #(
    parameter int DATA_W = 32
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);

    localparam int            CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    // ------------------------------------------------------------------
    // Sign handling helpers
    // ------------------------------------------------------------------
    // Magnitude of a two's complement value; the most negative value maps
    // to itself, which is its correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] ux;
        ux = x;
        return x[DATA_W-1] ? (~ux + 1'b1) : ux;
    endfunction

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] x,
                                                input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] x,
                                                   input logic en);
        return en ? (~x + 1'b1) : x;
    endfunction

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             iterate;
    logic             finish_wr;

    // ------------------------------------------------------------------
    // Datapath state (not reset: only meaningful after an accept)
    // ------------------------------------------------------------------
    // acc_q holds {partial product} for multiply and {remainder, quotient}
    // for divide; opnd_q holds the multiplicand or the divisor magnitude.
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0]   opnd_q;
    logic [DATA_W-1:0]   a_raw_q;
    logic                is_div_q;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic                div_zero_q;

    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                done_q;

    logic                sgn_in;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= '0;
            end else if (iterate) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    // cancel beats start in IDLE, and beats the result write in FINISH.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        iterate   = 1'b0;
        finish_wr = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.cancel) begin
                    state_nxt = CALC;
                    accept    = 1'b1;
                end
            end
            CALC: begin
                if (bus.cancel) begin
                    state_nxt = IDLE;
                end else begin
                    iterate = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
                if (!bus.cancel) begin
                    finish_wr = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    always_comb begin
        sgn_in = ~bus.op[0];
        a_mag  = sgn_in ? mag(bus.src_a) : bus.src_a;
        b_mag  = sgn_in ? mag(bus.src_b) : bus.src_b;
    end

    // ------------------------------------------------------------------
    // One radix-2 iteration
    // ------------------------------------------------------------------
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift right keeping the carry.
    // Divide: shift {rem,quo} left, trial-subtract the divisor and keep the
    // difference only if it did not go negative (restoring division).
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                  + (acc_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
        div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (is_div_q) begin
            if (div_diff[DATA_W]) begin
                acc_nxt = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
            end else begin
                acc_nxt = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
            end
        end else begin
            acc_nxt = {mul_sum, acc_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_q   <= bus.op[1];
            a_raw_q    <= bus.src_a;
            neg_res_q  <= sgn_in & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
            neg_rem_q  <= sgn_in & bus.src_a[DATA_W-1];
            div_zero_q <= (bus.src_b == '0);
            opnd_q     <= bus.op[1] ? b_mag : a_mag;
            acc_q      <= bus.op[1] ? {{DATA_W{1'b0}}, a_mag}
                                    : {{DATA_W{1'b0}}, b_mag};
        end else if (iterate) begin
            acc_q <= acc_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and special cases
    // ------------------------------------------------------------------
    // Signed overflow (most-negative / -1) needs no special path: the
    // magnitude quotient 2^(DATA_W-1) negates to itself.
    always_comb begin
        prod = neg_2w(acc_q, neg_res_q);
        if (!is_div_q) begin
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
        end else if (div_zero_q) begin
            res_hi = a_raw_q;
            res_lo = '1;
        end else begin
            res_hi = neg_w(acc_q[2*DATA_W-1:DATA_W], neg_rem_q);
            res_lo = neg_w(acc_q[DATA_W-1:0], neg_res_q);
        end
    end

    // ------------------------------------------------------------------
    // HI/LO and done
    // ------------------------------------------------------------------
    // MTHI/MTLO are honoured only in IDLE (including the accepting edge);
    // the result write in FINISH always takes priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (finish_wr) begin
                hi_q   <= res_hi;
                lo_q   <= res_lo;
                done_q <= 1'b1;
            end else if (state == IDLE) begin
                if (bus.hi_we) begin
                    hi_q <= bus.wdata;
                end
                if (bus.lo_we) begin
                    lo_q <= bus.wdata;
                end
            end
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.done = done_q;
    assign bus.busy = (state != IDLE);

endmodule
